// File: rtl/kronos_dmem_responder.sv
// Word-organised data-memory responder for the Kronos data bus.
// Optional bounds checking: define KRONOS_DMEM_BOUNDS_CHECK_EN.
module kronos_dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic [31:0] data_rd_data,
  output logic        data_gnt,
  output logic        data_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic            wr_q;
  logic            oor_q;

  logic [31:0] MEM [0:DEPTH-1];

  logic            req;
  logic [AW-1:0]   live_idx;
  logic            live_oor;

  logic            acc_now;
  logic            acc_wr;
  logic            acc_oor;
  logic [AW-1:0]   acc_idx;
  logic            mem_we;

  assign req      = data_rd_req | data_wr_req;
  assign live_idx = data_addr[2+:AW];

`ifdef KRONOS_DMEM_BOUNDS_CHECK_EN
  assign live_oor = data_addr[31:2] >= 30'(DEPTH);
  logic unused_addr;
  assign unused_addr = ^data_addr[1:0];
`else
  assign live_oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{data_addr[31:2+AW], data_addr[1:0]};
`endif

  // With no wait states the access happens on the sampling edge itself,
  // so it must use the live request rather than the latched copy.
  always_comb begin
    acc_now = 1'b0;
    acc_wr  = wr_q;
    acc_oor = oor_q;
    acc_idx = idx_q;
    unique case (state)
      S_IDLE: begin
        acc_now = req && (WAIT_CYCLES == 0);
        acc_wr  = data_wr_req;
        acc_oor = live_oor;
        acc_idx = live_idx;
      end
      S_WAIT: begin
        acc_now = (cnt == 4'd0);
      end
      default: begin
        acc_now = 1'b0;
      end
    endcase
  end

  assign mem_we = rstz & acc_now & acc_wr & ~acc_oor;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wr_mask[b]) begin
          MEM[acc_idx][8*b+:8] <= data_wr_data[8*b+:8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      idx_q        <= '0;
      wr_q         <= 1'b0;
      oor_q        <= 1'b0;
      data_gnt     <= 1'b0;
      data_err     <= 1'b0;
      data_rd_data <= 32'h0;
    end else begin
      data_gnt <= 1'b0;
      data_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            wr_q  <= data_wr_req;
            idx_q <= live_idx;
            oor_q <= live_oor;
            if (WAIT_CYCLES != 0) begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (acc_now) begin
        state    <= S_GRANT;
        data_gnt <= 1'b1;
        data_err <= acc_oor;
        if (!acc_wr) begin
          data_rd_data <= acc_oor ? 32'h0 : MEM[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_kronos_dmem_responder.sv
// Randomized self-checking bench for kronos_dmem_responder.
// Reference model: word array, last-read register, fixed latency.
module tb_kronos_dmem_responder;

  localparam int DEPTH = 16;
  localparam int W     = 3;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr_data = '0;
  logic [3:0]  data_wr_mask = '0;
  logic        data_rd_req = 1'b0;
  logic        data_wr_req = 1'b0;
  logic [31:0] data_rd_data;
  logic        data_gnt;
  logic        data_err;

  kronos_dmem_responder #(
    .DEPTH(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rstz(rstz),
    .data_addr(data_addr),
    .data_wr_data(data_wr_data),
    .data_wr_mask(data_wr_mask),
    .data_rd_req(data_rd_req),
    .data_wr_req(data_wr_req),
    .data_rd_data(data_rd_data),
    .data_gnt(data_gnt),
    .data_err(data_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    data_rd_req = 1'b0;
    data_wr_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_gnt", {31'b0, data_gnt}, 32'd0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input bit hold,
                        output int gnt_cyc);
    int  idx;
    bit  oor;
    idx = int'((addr >> 2) % DEPTH);
`ifdef KRONOS_DMEM_BOUNDS_CHECK_EN
    oor = (addr >> 2) >= DEPTH;
`else
    oor = 1'b0;
`endif
    data_addr    = addr;
    data_wr_data = data;
    data_wr_mask = mask;
    data_rd_req  = rd;
    data_wr_req  = wr;
    if (wr) begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (mask[b]) model[idx][8*b+:8] = data[8*b+:8];
    end else begin
      last_rd = oor ? 32'h0 : model[idx];
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("early_gnt", {31'b0, data_gnt}, 32'd0);
    end
    @(negedge clk);
    gnt_cyc = cyc;
    chk("gnt", {31'b0, data_gnt}, 32'd1);
    chk("rd_data", data_rd_data, last_rd);
    chk("err", {31'b0, data_err}, {31'b0, oor});
    if (!hold) begin
      data_rd_req = 1'b0;
      data_wr_req = 1'b0;
    end
    @(negedge clk);
    chk("gnt_pulse", {31'b0, data_gnt}, 32'd0);
  endtask

  int t1, t2;
  logic [31:0] v;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      model[i] = v;
      dut.MEM[i] = v;
    end
    model[5] = 32'hDEADBEEF;
    dut.MEM[5] = 32'hDEADBEEF;
    model[3] = 32'h11223344;
    dut.MEM[3] = 32'h11223344;

    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {31'b0, data_gnt}, 32'd0);
    chk("rst_rd", data_rd_data, 32'h0);
    chk("rst_err", {31'b0, data_err}, 32'd0);
    rstz = 1'b1;
    idle(2);

    access(1, 0, 32'h14, 0, 0, 0, t1);
    chk("rd_beef", data_rd_data, 32'hDEADBEEF);

    access(0, 1, 32'h0C, 32'hAABBCCDD, 4'b0110, 0, t1);
    access(1, 0, 32'h0C, 0, 0, 0, t1);
    chk("masked_rd", data_rd_data, 32'h11BBCC44);

    access(0, 1, 32'h08, $urandom, 4'b0000, 0, t1);
    access(1, 0, 32'h08, 0, 0, 0, t1);

    access(1, 0, 32'h24, 0, 0, 0, t1);
    access(1, 1, 32'h24, 32'h0, 4'hF, 0, t1);
    access(1, 0, 32'h24, 0, 0, 0, t1);
    chk("both_clr", data_rd_data, 32'h0);

    access(1, 0, 32'h14, 0, 0, 1, t1);
    access(1, 0, 32'h14, 0, 0, 0, t2);
    chk("b2b_gap", t2 - t1, W + 2);

    access(1, 0, 32'h400, 0, 0, 0, t1);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 3);
      access(r != 1, r == 1 || r == 2, $urandom_range(0, 255), $urandom,
             4'($urandom), 0, t1);
      idle($urandom_range(0, 2));
    end

    data_addr    = 32'h1C;
    data_wr_data = ~model[7];
    data_wr_mask = 4'hF;
    data_wr_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_gnt", {31'b0, data_gnt}, 32'd0);
    rstz = 1'b0;
    #1;
    chk("arst_gnt", {31'b0, data_gnt}, 32'd0);
    chk("arst_rd", data_rd_data, 32'h0);
    chk("arst_err", {31'b0, data_err}, 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    idle(4);
    rstz = 1'b1;
    idle(6);
    access(1, 0, 32'h1C, 0, 0, 0, t1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
